// File: rtl/sgndiv_32x32.sv
// sgndiv_32x32: sequential signed divider.
// Both operands are reduced to magnitudes and divided with one unsigned
// restoring shift-subtract iteration per clock. The signs are then re-applied
// so that the quotient truncates toward zero and the remainder takes the
// sign of the numerator. Divide-by-zero and the single signed overflow case
// (most-negative / -1) are detected at accept and substituted in FIX.
module sgndiv_32x32 #(
  parameter int NN = 32,
  parameter int ND = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_wr,
  input  logic signed [NN-1:0] i_num,
  input  logic signed [ND-1:0] i_den,
  input  logic                 i_aux,
  output logic                 o_busy,
  output logic                 o_valid,
  output logic                 o_err,
  output logic signed [NN-1:0] o_quot,
  output logic signed [ND-1:0] o_rem,
  output logic                 o_aux
);

  localparam int CW = (NN > 1) ? $clog2(NN) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, state_nxt;

  // Working registers; only the control path is reset.
  logic [NN-1:0] dvd;       // dividend magnitude, quotient bits shift in at LSB
  logic [ND-1:0] dvs;       // divisor magnitude
  logic [ND-1:0] pr;        // partial remainder
  logic [ND-1:0] num_lo;    // raw numerator low bits, returned on divide-by-zero
  logic [CW-1:0] cnt;
  logic          q_sgn;
  logic          r_sgn;
  logic          aux_l;
  logic          zero_l;
  logic          ovf_l;

  logic          accept;
  logic [ND:0]   pr_sh;     // shifted remainder window, one bit wider than pr
  logic [ND:0]   trial;
  logic          borrow;

  // Magnitude of a signed value; the most-negative value maps to 2^(W-1).
  function automatic logic [NN-1:0] mag_num(input logic signed [NN-1:0] v);
    mag_num = v[NN-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [ND-1:0] mag_den(input logic signed [ND-1:0] v);
    mag_den = v[ND-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  // Re-apply a sign to an unsigned magnitude.
  function automatic logic signed [NN-1:0] sgn_q(input logic neg, input logic [NN-1:0] m);
    sgn_q = neg ? $signed(-m) : $signed(m);
  endfunction

  function automatic logic signed [ND-1:0] sgn_r(input logic neg, input logic [ND-1:0] m);
    sgn_r = neg ? $signed(-m) : $signed(m);
  endfunction

  assign accept = (state == IDLE) && i_wr;
  assign o_busy = (state != IDLE);

  // One restoring step: shift in the next dividend bit, trial-subtract.
  // pr < dvs always holds between steps, so bit ND of the difference is the borrow.
  assign pr_sh  = {pr, dvd[NN-1]};
  assign trial  = pr_sh - {1'b0, dvs};
  assign borrow = trial[ND];

  // State register; reset wins over every other event.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic: IDLE -> RUN on request, NN iterations, one FIX cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_wr) state_nxt = RUN;
      RUN:  if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture at accept and shift-subtract iterations during RUN.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      dvd    <= mag_num(i_num);
      dvs    <= mag_den(i_den);
      pr     <= '0;
      num_lo <= i_num[ND-1:0];
      cnt    <= CW'(NN - 1);
      q_sgn  <= i_num[NN-1] ^ i_den[ND-1];
      r_sgn  <= i_num[NN-1];
      aux_l  <= i_aux;
      zero_l <= (i_den == '0);
      ovf_l  <= (i_num == {1'b1, {(NN-1){1'b0}}}) && (i_den == '1);
    end else if (state == RUN) begin
      pr  <= borrow ? pr_sh[ND-1:0] : trial[ND-1:0];
      dvd <= {dvd[NN-2:0], ~borrow};
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  // Result registers: updated only in FIX and held until the next FIX.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      o_aux   <= 1'b0;
      o_quot  <= '0;
      o_rem   <= '0;
    end else begin
      o_valid <= (state == FIX);
      if (state == FIX) begin
        o_aux <= aux_l;
        if (zero_l) begin
          o_quot <= '1;
          o_rem  <= num_lo;
          o_err  <= 1'b1;
        end else if (ovf_l) begin
          o_quot <= {1'b1, {(NN-1){1'b0}}};
          o_rem  <= '0;
          o_err  <= 1'b1;
        end else begin
          o_quot <= sgn_q(q_sgn, dvd);
          o_rem  <= sgn_r(r_sgn, pr);
          o_err  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/sgndiv_32x32.md
# sgndiv_32x32

Sequential signed integer divider, the inverse of the signed multiply path in the multiply core generator. It accepts an NN-bit signed numerator and an ND-bit signed denominator, then strips signs into magnitudes. It runs an NN-iteration unsigned restoring shift-subtract loop, re-applies signs, and returns a truncated (round-toward-zero) quotient and remainder. It is used alongside the multiply cores wherever a CPU or DSP datapath needs divide without a hard DSP divider.

## Interface

- NN, 32, numerator and quotient width (bits).
- ND, 32, denominator and remainder width (bits); ND <= NN.
- i_clk  input  1  clock; all logic on rising edge.
- i_reset_n  input  1  synchronous, active-low reset.
- i_wr  input  1  request strobe; accepted only when o_busy is low.
- i_num  input  NN  signed numerator.
- i_den  input  ND  signed denominator.
- i_aux  input  1  side-band bit, returned with the result.
- o_busy  output  1  divider occupied; requests ignored.
- o_valid  output  1  one-cycle result strobe.
- o_err  output  1  divide-by-zero or overflow, qualified by o_valid.
- o_quot  output  NN  signed quotient.
- o_rem  output  ND  signed remainder.
- o_aux  output  1  i_aux captured at accept.

## Operation

- States: IDLE, RUN, FIX.
- IDLE, i_wr=1:
  - capture |i_num| into an NN-bit unsigned dividend and |i_den| into an ND-bit unsigned divisor.
  - The magnitude of the most-negative value is represented as 2^(NN-1) or 2^(ND-1) unsigned.
  - Latch q_sgn = i_num[NN-1]^i_den[ND-1], r_sgn = i_num[NN-1], and i_aux.
  - Latch zero = (i_den==0) and ovf = (i_num==-2^(NN-1) && i_den==-1).
  - Load counter = NN-1, clear the partial remainder (ND+1 bits), set o_busy. Go to RUN.
- RUN, one iteration per clock:
  - Shift the partial remainder left, bringing in the dividend MSB.
  - Trial-subtract the divisor. If there is no borrow, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - When counter==0, go to FIX; otherwise decrement the counter.
- FIX, one clock:
  - o_quot = q_sgn ? -uq : uq; o_rem = r_sgn ? -ur : ur.
  - zero: o_quot = all ones (-1), o_rem = i_num[ND-1:0] as captured, o_err = 1.
  - ovf: o_quot = -2^(NN-1), o_rem = 0, o_err = 1.
  - Assert o_valid and o_aux, clear o_busy, go to IDLE.
- Identity: num == quot*den + rem, |rem| < |den|, and sign(rem) == sign(num) or rem == 0. This holds for every non-error case.
- o_quot, o_rem, o_err and o_aux hold their values until the next FIX. Only o_valid is a pulse.
- i_wr while o_busy=1 is dropped silently, with no queueing and no effect on the running operation.

## Timing

- Reset (i_reset_n=0 at an edge): state=IDLE. o_busy, o_valid, o_err, o_aux = 0; o_quot = 0; o_rem = 0.
  - Reset takes priority over every other event, including mid-RUN and FIX.
  - An operation in progress is discarded and no o_valid is produced.
- Latency: i_wr sampled at edge k, o_busy=1 after edge k, o_valid=1 after edge k+NN+1 (RUN occupies edges k+1..k+NN, FIX at edge k+NN+1), so o_valid is seen NN+1 cycles after acceptance; NN=32 gives 33.
- o_busy falls in the same cycle o_valid rises, so a new i_wr in the o_valid cycle is accepted. Back-to-back throughput is one result per NN+1 cycles.
- Error cases (zero, ovf) take the same fixed latency as normal divides.
- i_wr during reset is ignored.

## Test plan

- 100 / 7 -> o_valid exactly 33 cycles after accept; quot=14, rem=2, err=0. -100/7 -> -14, -2. 100/-7 -> -14, 2. -100/-7 -> 14, -2.
- -2^31 / 1 -> quot=0x80000000, rem=0, err=0. -2^31 / -1 -> quot=0x80000000, rem=0, err=1. 7 / -2^31 -> quot=0, rem=7.
- 12345 / 0 -> err=1, quot=0xFFFFFFFF, rem=12345, same 33-cycle latency. i_aux=1 at accept -> o_aux=1 with o_valid.
- Assert i_wr every cycle during a divide -> exactly one result per 33 cycles. Each result matches the operands presented at its accept edge; requests made while busy are dropped.
- Pull i_reset_n low at RUN cycle 10 -> next cycle all outputs 0 and state IDLE, no o_valid. A divide issued after release completes normally.
- Random sweep of 10^5 operand pairs including 0, ±1, ±max and min -> identity and remainder bound hold; results match a reference model of truncated division.
